// File: rtl/lcd_msg_sequencer.sv
// Message front-end for the 16x2 LCD: renders a message code plus BCD ID into two
// centred text lines, expires transient messages, and hands frames over req/ack.
module lcd_msg_sequencer #(
    parameter int          ID_DIGITS      = 7,
    parameter int          HOLD_CYCLES    = 100_000_000,
    parameter logic [15:0] TRANSIENT_MASK = 16'h38A6,
    parameter logic [3:0]  IDLE_CODE      = 4'd0
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [3:0]             iMSG_CODE,
    input  logic                   iMSG_VALID,
    input  logic [4*ID_DIGITS-1:0] iID,
    input  logic                   iFRAME_ACK,
    output logic [127:0]           oLINE1,
    output logic [127:0]           oLINE2,
    output logic                   oFRAME_REQ,
    output logic [3:0]             oCUR_CODE,
    output logic                   oHOLD_ACTIVE
);

    localparam int             IDW       = 4 * ID_DIGITS;
    localparam int             CW        = $clog2(HOLD_CYCLES);
    // Expiry fires on the edge that moves the counter onto HOLD_CYCLES-1.
    localparam logic [CW-1:0]  EXPIRE_AT = CW'(HOLD_CYCLES - 2);
    localparam logic [127:0]   BLANK     = {16{8'h20}};

    typedef enum logic {
        F_IDLE,
        F_REQ
    } frame_state_e;

    function automatic logic has_id(input logic [3:0] code);
        return (code == 4'd1) || (code == 4'd11) || (code == 4'd12) || (code == 4'd14);
    endfunction

    function automatic logic [7:0] bcd_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    // Raw text is right-aligned in the low bytes with zero bytes above, as a string literal.
    function automatic logic [127:0] center(input logic [127:0] s);
        int           len;
        int           pad;
        logic [127:0] line;
        len = 0;
        for (int i = 0; i < 16; i++) begin
            if (s[8*i +: 8] != 8'h00) len = i + 1;
        end
        pad  = (16 - len) / 2;
        line = BLANK;
        for (int p = 0; p < 16; p++) begin
            if (p >= pad && p < pad + len) line[127-8*p -: 8] = s[8*(len-1-(p-pad)) +: 8];
        end
        return line;
    endfunction

    function automatic logic [127:0] id_text(input logic [IDW-1:0] id);
        logic [127:0] s;
        s = '0;
        s[8*ID_DIGITS +: 32] = "ID: ";
        for (int d = 0; d < ID_DIGITS; d++) begin
            s[8*d +: 8] = bcd_char(id[4*d +: 4]);
        end
        return s;
    endfunction

    function automatic logic [255:0] render(input logic [3:0] code, input logic [IDW-1:0] id);
        logic [127:0] t1;
        logic [127:0] t2;
        t1 = '0;
        t2 = '0;
        case (code)
            4'd0:    begin t1 = 128'("Enter Your");       t2 = 128'("ID to Park");      end
            4'd1:    begin t1 = 128'("ACCESS GRANTED");   t2 = id_text(id);             end
            4'd2:    begin t1 = 128'("ACCESS DENIED");    t2 = 128'("Try Again");       end
            4'd3:    begin t1 = 128'("Enter Your");       t2 = 128'("ID to Exit");      end
            4'd4:    begin t1 = 128'("No Spaces");        t2 = 128'("Left");            end
            4'd5:    begin t1 = 128'("Administrator");    t2 = 128'("Mode");            end
            4'd6:    begin t1 = 128'("Enter Your");       t2 = 128'("Admin ID");        end
            4'd7:    begin t1 = 128'("Admin ACCESS");     t2 = 128'("DENIED");          end
            4'd8:    begin t1 = 128'("1- Open the Gate"); t2 = 128'("2- Restrict Acc"); end
            4'd9:    begin t1 = 128'("Gate is Open");     t2 = '0;                      end
            4'd10:   begin t1 = 128'("Enter ID to");      t2 = 128'("Restrict");        end
            4'd11:   begin t1 = id_text(id);              t2 = 128'("Is RESTRICTED");   end
            4'd12:   begin t1 = id_text(id);              t2 = 128'("Is UNRESTRICTED"); end
            4'd13:   begin t1 = 128'("Invalid ID");       t2 = 128'("To Restrict");     end
            4'd14:   begin t1 = id_text(id);              t2 = 128'("Exiting");         end
            default: begin t1 = 128'("Parking");          t2 = 128'("OFF");             end
        endcase
        return {center(t1), center(t2)};
    endfunction

    frame_state_e   state_q, state_d;
    logic [127:0]   line1_q, line1_d;
    logic [127:0]   line2_q, line2_d;
    logic           req_q, req_d;
    logic [3:0]     cur_code_q, cur_code_d;
    logic [IDW-1:0] cur_id_q, cur_id_d;
    logic [3:0]     tgt_code_q, tgt_code_d;
    logic [IDW-1:0] tgt_id_q, tgt_id_d;
    logic           pend_q, pend_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hold_q, hold_d;

    logic           load;
    logic [255:0]   rendered;
    logic [3:0]     ref_code;
    logic [IDW-1:0] ref_id;
    logic           differs;
    logic           expire;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_d    = state_q;
        line1_d    = line1_q;
        line2_d    = line2_q;
        req_d      = req_q;
        cur_code_d = cur_code_q;
        cur_id_d   = cur_id_q;
        load       = 1'b0;
        rendered   = render(tgt_code_q, tgt_id_q);

        case (state_q)
            F_IDLE: begin
                if (pend_q) begin
                    load       = 1'b1;
                    line1_d    = rendered[255:128];
                    line2_d    = rendered[127:0];
                    cur_code_d = tgt_code_q;
                    cur_id_d   = tgt_id_q;
                    req_d      = 1'b1;
                    state_d    = F_REQ;
                end
            end
            default: begin
                if (iFRAME_ACK) begin
                    req_d   = 1'b0;
                    state_d = F_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        // Duplicates are judged against what is on the lines after this edge.
        ref_code   = load ? tgt_code_q : cur_code_q;
        ref_id     = load ? tgt_id_q   : cur_id_q;
        differs    = (iMSG_CODE != ref_code) || (has_id(iMSG_CODE) && (iID != ref_id));
        expire     = hold_q && (cnt_q == EXPIRE_AT);

        tgt_code_d = tgt_code_q;
        tgt_id_d   = tgt_id_q;
        pend_d     = load ? 1'b0 : pend_q;
        hold_d     = hold_q;
        cnt_d      = hold_q ? cnt_q + CW'(1) : cnt_q;

        if (iMSG_VALID) begin
            tgt_code_d = iMSG_CODE;
            tgt_id_d   = iID;
            pend_d     = pend_d | differs;
            if (TRANSIENT_MASK[iMSG_CODE]) begin
                cnt_d  = '0;
                hold_d = 1'b1;
            end else begin
                hold_d = 1'b0;
            end
        end else if (expire) begin
            tgt_code_d = IDLE_CODE;
            tgt_id_d   = '0;
            pend_d     = 1'b1;
            hold_d     = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= F_IDLE;
            line1_q    <= BLANK;
            line2_q    <= BLANK;
            req_q      <= 1'b0;
            cur_code_q <= IDLE_CODE;
            cur_id_q   <= '0;
            tgt_code_q <= IDLE_CODE;
            tgt_id_q   <= '0;
            pend_q     <= 1'b1;
            cnt_q      <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line1_q    <= line1_d;
            line2_q    <= line2_d;
            req_q      <= req_d;
            cur_code_q <= cur_code_d;
            cur_id_q   <= cur_id_d;
            tgt_code_q <= tgt_code_d;
            tgt_id_q   <= tgt_id_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign oLINE1       = line1_q;
    assign oLINE2       = line2_q;
    assign oFRAME_REQ   = req_q;
    assign oCUR_CODE    = cur_code_q;
    assign oHOLD_ACTIVE = hold_q;

endmodule

// File: doc/lcd_msg_sequencer.md
Name: lcd_msg_sequencer

Overview:
- Parametrised message front-end for the 16x2 character LCD path.
- Accepts a 4-bit message code plus a BCD ID of configurable digit count, and renders two 128-bit line buffers.
- Auto-returns transient messages to the idle screen after a programmable hold time.
- Hands each new frame to the LCD driver over a req/ack handshake, so line contents are stable for the whole write.

Parameters:
ID_DIGITS, 7, number of BCD digits in iID (1..9)
HOLD_CYCLES, 100_000_000, iCLK cycles a transient message stays displayed (>=2)
TRANSIENT_MASK, 16'h38A6, bit n set = code n is transient (default codes 1,2,5,7,11,12,13)
IDLE_CODE, 4'd0, code shown after reset and after a transient expires

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iMSG_CODE  in  4  requested message code
iMSG_VALID  in  1  one-cycle strobe; code/ID sampled this cycle
iID  in  4*ID_DIGITS  BCD ID, most significant digit in MSBs
iFRAME_ACK  in  1  LCD driver has consumed the current frame
oLINE1  out  128  line 1 ASCII, char 0 in bits [127:120]
oLINE2  out  128  line 2 ASCII
oFRAME_REQ  out  1  new frame on oLINE1/oLINE2 awaiting write
oCUR_CODE  out  4  code currently presented on oLINE1/oLINE2
oHOLD_ACTIVE  out  1  transient hold timer running

Behaviour:
- Reset (async, iRST_N=0):
  - oLINE1/oLINE2 = 16 x 8'h20; oFRAME_REQ=0; oCUR_CODE=IDLE_CODE; oHOLD_ACTIVE=0; hold counter=0.
  - Target = {IDLE_CODE, ID=0}; pending flag = 1.
- Text table: each string is centred in 16 chars with left pad = floor((16-len)/2), the rest padded with spaces.
  - 0 "Enter Your"/"ID to Park"
  - 1 "ACCESS GRANTED"/ID field
  - 2 "ACCESS DENIED"/"Try Again"
  - 3 "Enter Your"/"ID to Exit"
  - 4 "No Spaces"/"Left"
  - 5 "Administrator"/"Mode"
  - 6 "Enter Your"/"Admin ID"
  - 7 "Admin ACCESS"/"DENIED"
  - 8 "1- Open the Gate"/"2- Restrict Acc"
  - 9 "Gate is Open"/blank
  - 10 "Enter ID to"/"Restrict"
  - 11 ID field/"Is RESTRICTED"
  - 12 ID field/"Is UNRESTRICTED"
  - 13 "Invalid ID"/"To Restrict"
  - 14 ID field/"Exiting"
  - 15 "Parking"/"OFF"
- ID field: "ID: " followed by ID_DIGITS characters, centred as one string.
  - Digit 0-9 maps to 8'h30+d; any digit >9 maps to '?' (8'h3F).
- Accept: on iMSG_VALID, target <= {iMSG_CODE, iID}.
  - Pending is set only if the new target differs from the target last presented. For codes without an ID field, iID is ignored in this comparison.
- Frame FSM:
  - F_IDLE: if pending, load rendered target into oLINE1/oLINE2/oCUR_CODE, set oFRAME_REQ=1, clear pending -> F_REQ. Lines update one cycle after pending is set.
  - F_REQ: lines frozen. On iFRAME_ACK, oFRAME_REQ<=0 -> F_IDLE.
  - New accepts during F_REQ only update target/pending. The latest target wins; intermediate targets are dropped.
  - iFRAME_ACK while in F_IDLE is ignored.
- Hold timer:
  - Any accepted iMSG_VALID with TRANSIENT_MASK[code]=1 clears the counter and sets oHOLD_ACTIVE. This includes a duplicate, which restarts the timer without a new frame.
  - An accept of a non-transient code clears oHOLD_ACTIVE.
  - The counter increments each cycle while active. When it reaches HOLD_CYCLES-1: target <= {IDLE_CODE, 0}, pending set, oHOLD_ACTIVE cleared.
  - iMSG_VALID in the same cycle as expiry takes priority: expiry is discarded.
  - The timer runs independently of the handshake. Expiry during F_REQ queues the idle frame.
- Counter width = $clog2(HOLD_CYCLES); it never wraps.
- Reset mid-handshake aborts immediately: oFRAME_REQ drops asynchronously.

Test Plan:
- Release reset, ack after 3 cycles -> oFRAME_REQ rises 1 cycle after release; oLINE1="   Enter Your   ", oLINE2="   ID to Park   "; oCUR_CODE=0.
- HOLD_CYCLES=10: strobe code 1, iID=28'h1234567 -> oLINE2="  ID: 1234567   "; ack; idle frame request exactly 10 cycles after the strobe.
- Strobe code 2, then code 8 two cycles later while REQ is held without ack; ack -> frame 8 follows immediately; frame for code 2 keeps its lines until ack; oHOLD_ACTIVE=0.
- Strobe code 8 twice with no change -> exactly one oFRAME_REQ pulse.
- Code 11 with iID digit 4'hA in position 3 -> '?' at that ID character.
- Strobe code 7 on the expiry cycle of a prior transient -> code 7 shown, timer restarted, no idle frame. Then assert iRST_N=0 during REQ -> oFRAME_REQ=0 and lines all spaces immediately.
